// File: rtl/trap_sequencer.sv
// Purpose : PC redirect sequencer for timer interrupt and abnormal (exception) traps.
// Latency : request edge pends at edge N, decision at N+1, redirect_o high the cycle after N+1.
// Backpr. : decisions and eret wait for a free front-end slot (stall0_i=0, branch_i=0).
//
// Ports:
//   clk, reset_jump_inte_abn   clock (rising edge), async active-high reset
//   req_timer_i, req_abn_i     level requests; a rising edge is one new request
//   eret_i                     1-cycle return-from-trap strobe
//   stall0_i, branch_i         front-end slot blockers
//   pc_i                       current PC
//   redirect_o/redirect_addr_o 1-cycle redirect strobe and its target
//   ret_addr_o                 saved return address (pc_i - PC_OFFSET at decision)
//   kernel_o                   1 while in trap handler; new traps are masked
//   cause_o                    01 timer, 10 abnormal, 00 none (last trap taken)
module trap_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] VEC_INT   = 'h4,
    parameter logic [ADDR_W-1:0] VEC_EXC   = 'h8,
    parameter int                PC_OFFSET = 4
) (
    input  logic              clk,
    input  logic              reset_jump_inte_abn,
    input  logic              req_timer_i,
    input  logic              req_abn_i,
    input  logic              eret_i,
    input  logic              stall0_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic [ADDR_W-1:0] ret_addr_o,
    output logic              kernel_o,
    output logic [1:0]        cause_o
);

    localparam logic [ADDR_W-1:0] OFFS = ADDR_W'(PC_OFFSET);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAKE   = 2'd1,
        KERNEL = 2'd2,
        RET    = 2'd3
    } state_t;

    state_t state, state_d;

    logic req_t_q, req_a_q;
    logic pend_t, pend_a;
    logic pend_t_d, pend_a_d;
    logic eret_hold, eret_hold_d;
    logic take_t, take_a;
    logic slot_ok;
    logic rise_t, rise_a;

    assign slot_ok = ~stall0_i & ~branch_i;
    assign rise_t  = req_timer_i & ~req_t_q;
    assign rise_a  = req_abn_i & ~req_a_q;

    always_comb begin
        state_d     = state;
        take_t      = 1'b0;
        take_a      = 1'b0;
        eret_hold_d = eret_hold;
        case (state)
            IDLE: begin
                // eret outside the handler is meaningless; never carry it in.
                eret_hold_d = 1'b0;
                if (slot_ok) begin
                    if (pend_a) begin
                        take_a  = 1'b1;
                        state_d = TAKE;
                    end else if (pend_t) begin
                        take_t  = 1'b1;
                        state_d = TAKE;
                    end
                end
            end
            TAKE: begin
                state_d = KERNEL;
            end
            KERNEL: begin
                // An eret arriving while the slot is busy is remembered until it frees.
                if (eret_i | eret_hold) begin
                    if (slot_ok) begin
                        state_d     = RET;
                        eret_hold_d = 1'b0;
                    end else begin
                        eret_hold_d = 1'b1;
                    end
                end
            end
            RET: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Taking a source clears it even if a new edge arrives the same cycle.
        pend_t_d = take_t ? 1'b0 : (pend_t | rise_t);
        pend_a_d = take_a ? 1'b0 : (pend_a | rise_a);
    end

    always_ff @(posedge clk or posedge reset_jump_inte_abn) begin
        if (reset_jump_inte_abn) begin
            state           <= IDLE;
            req_t_q         <= 1'b0;
            req_a_q         <= 1'b0;
            pend_t          <= 1'b0;
            pend_a          <= 1'b0;
            eret_hold       <= 1'b0;
            redirect_o      <= 1'b0;
            redirect_addr_o <= '0;
            ret_addr_o      <= '0;
            kernel_o        <= 1'b0;
            cause_o         <= 2'b00;
        end else begin
            state      <= state_d;
            req_t_q    <= req_timer_i;
            req_a_q    <= req_abn_i;
            pend_t     <= pend_t_d;
            pend_a     <= pend_a_d;
            eret_hold  <= eret_hold_d;
            // Outputs are registered from next state so nothing combinational leaves the block.
            redirect_o <= (state_d == TAKE) || (state_d == RET);
            kernel_o   <= (state_d != IDLE);
            if (take_a || take_t) begin
                ret_addr_o      <= pc_i - OFFS;
                cause_o         <= take_a ? 2'b10 : 2'b01;
                redirect_addr_o <= take_a ? VEC_EXC : VEC_INT;
            end else if (state == KERNEL && state_d == RET) begin
                redirect_addr_o <= ret_addr_o;
            end
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer: directed steps, redirect scoreboard, immediate-assert checks.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset_jump_inte_abn;
    logic        req_timer_i, req_abn_i, eret_i, stall0_i, branch_i;
    logic [31:0] pc_i;
    logic        redirect_o;
    logic [31:0] redirect_addr_o, ret_addr_o;
    logic        kernel_o;
    logic [1:0]  cause_o;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_q[$];
    logic        prev_redirect = 1'b0;

    trap_sequencer dut (
        .clk                (clk),
        .reset_jump_inte_abn(reset_jump_inte_abn),
        .req_timer_i        (req_timer_i),
        .req_abn_i          (req_abn_i),
        .eret_i             (eret_i),
        .stall0_i           (stall0_i),
        .branch_i           (branch_i),
        .pc_i               (pc_i),
        .redirect_o         (redirect_o),
        .redirect_addr_o    (redirect_addr_o),
        .ret_addr_o         (ret_addr_o),
        .kernel_o           (kernel_o),
        .cause_o            (cause_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every redirect pops the oldest expected target.
    always @(negedge clk) begin
        if (!reset_jump_inte_abn && redirect_o) begin
            check("no_back_to_back", {31'b0, prev_redirect}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_redirect", redirect_addr_o, 32'hDEAD_BEEF);
            end else begin
                check("sb_redirect_addr", redirect_addr_o, exp_q.pop_front());
            end
        end
        prev_redirect = redirect_o & ~reset_jump_inte_abn;
    end

    // One eret pulse followed by the RET redirect and return to IDLE.
    task automatic do_eret(input logic [31:0] ret);
        exp_q.push_back(ret);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        check("eret_redirect", {31'b0, redirect_o}, 32'd1);
        check("eret_addr", redirect_addr_o, ret);
        tick();
        check("kernel_after_ret", {31'b0, kernel_o}, 32'd0);
    endtask

    initial begin
        reset_jump_inte_abn = 1'b1;
        req_timer_i = 1'b0; req_abn_i = 1'b0; eret_i = 1'b0;
        stall0_i = 1'b0; branch_i = 1'b0; pc_i = 32'h100;
        tick(); tick();
        check("rst_redirect", {31'b0, redirect_o}, 32'd0);
        check("rst_addr", redirect_addr_o, 32'd0);
        check("rst_ret", ret_addr_o, 32'd0);
        check("rst_kernel", {31'b0, kernel_o}, 32'd0);
        check("rst_cause", {30'b0, cause_o}, 32'd0);
        reset_jump_inte_abn = 1'b0;
        tick();

        // 1: timer, basic latency and return address
        req_timer_i = 1'b1; exp_q.push_back(32'h4);
        tick();
        check("t1_no_redirect_yet", {31'b0, redirect_o}, 32'd0);
        tick();
        check("t1_redirect", {31'b0, redirect_o}, 32'd1);
        check("t1_addr", redirect_addr_o, 32'h4);
        check("t1_ret", ret_addr_o, 32'hFC);
        check("t1_cause", {30'b0, cause_o}, 32'd1);
        check("t1_kernel", {31'b0, kernel_o}, 32'd1);
        tick();
        req_timer_i = 1'b0;
        check("t1_single_cycle", {31'b0, redirect_o}, 32'd0);
        check("t1_kernel_hold", {31'b0, kernel_o}, 32'd1);
        do_eret(32'hFC);

        // 2: simultaneous requests, abnormal wins, timer taken after return
        pc_i = 32'h200;
        req_timer_i = 1'b1; req_abn_i = 1'b1; exp_q.push_back(32'h8);
        tick(); tick();
        check("t2_addr", redirect_addr_o, 32'h8);
        check("t2_cause", {30'b0, cause_o}, 32'd2);
        check("t2_ret", ret_addr_o, 32'h1FC);
        tick();
        req_timer_i = 1'b0; req_abn_i = 1'b0;
        tick(); tick();
        check("t2_masked", {31'b0, redirect_o}, 32'd0);
        pc_i = 32'h300;
        do_eret(32'h1FC);
        exp_q.push_back(32'h4);
        check("t2_idle_gap", {31'b0, redirect_o}, 32'd0);
        tick();
        check("t2_second_redirect", {31'b0, redirect_o}, 32'd1);
        check("t2_second_addr", redirect_addr_o, 32'h4);
        check("t2_second_cause", {30'b0, cause_o}, 32'd1);
        check("t2_second_ret", ret_addr_o, 32'h2FC);
        tick();
        do_eret(32'h2FC);

        // 3: stall and branch block the decision; eret held across a stall
        pc_i = 32'h400;
        stall0_i = 1'b1; req_abn_i = 1'b1; exp_q.push_back(32'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stalled", {31'b0, redirect_o}, 32'd0);
        end
        stall0_i = 1'b0;
        tick();
        check("t3_after_stall", {31'b0, redirect_o}, 32'd1);
        check("t3_addr", redirect_addr_o, 32'h8);
        tick();
        req_abn_i = 1'b0;
        exp_q.push_back(32'h3FC);
        stall0_i = 1'b1; eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        check("t3_eret_stalled", {31'b0, redirect_o}, 32'd0);
        tick();
        check("t3_eret_still", {31'b0, redirect_o}, 32'd0);
        stall0_i = 1'b0;
        tick();
        check("t3_eret_held", {31'b0, redirect_o}, 32'd1);
        check("t3_eret_addr", redirect_addr_o, 32'h3FC);
        tick();
        branch_i = 1'b1; req_timer_i = 1'b1; exp_q.push_back(32'h4);
        tick(); tick();
        check("t3_branch_block", {31'b0, redirect_o}, 32'd0);
        branch_i = 1'b0;
        tick();
        check("t3_after_branch", {31'b0, redirect_o}, 32'd1);
        tick();
        req_timer_i = 1'b0;
        do_eret(32'h3FC);

        // 4: held level is one request; re-rise in KERNEL taken after return
        pc_i = 32'h500;
        req_timer_i = 1'b1; exp_q.push_back(32'h4);
        for (int i = 0; i < 20; i++) tick();
        check("t4_kernel", {31'b0, kernel_o}, 32'd1);
        req_timer_i = 1'b0;
        tick();
        req_timer_i = 1'b1;
        tick(); tick();
        check("t4_masked", {31'b0, redirect_o}, 32'd0);
        do_eret(32'h4FC);
        exp_q.push_back(32'h4);
        tick();
        check("t4_retake", redirect_addr_o, 32'h4);
        tick();
        req_timer_i = 1'b0;
        do_eret(32'h4FC);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        tick(); tick();
        check("t4_eret_idle", {31'b0, redirect_o}, 32'd0);
        check("t4_eret_idle_k", {31'b0, kernel_o}, 32'd0);

        // 5: async reset in KERNEL with timer pending
        req_timer_i = 1'b1; exp_q.push_back(32'h4);
        tick(); tick(); tick();
        req_timer_i = 1'b0;
        tick();
        req_timer_i = 1'b1;
        tick();
        reset_jump_inte_abn = 1'b1;
        #1;
        check("t5_rst_kernel", {31'b0, kernel_o}, 32'd0);
        check("t5_rst_ret", ret_addr_o, 32'd0);
        check("t5_rst_cause", {30'b0, cause_o}, 32'd0);
        check("t5_rst_addr", redirect_addr_o, 32'd0);
        req_timer_i = 1'b0;
        tick();
        reset_jump_inte_abn = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_quiet", {31'b0, kernel_o}, 32'd0);

        // 6: return address wraps below zero
        pc_i = 32'h0;
        req_abn_i = 1'b1; exp_q.push_back(32'h8);
        tick(); tick();
        check("t6_ret_wrap", ret_addr_o, 32'hFFFF_FFFC);
        tick();
        req_abn_i = 1'b0;
        do_eret(32'hFFFF_FFFC);

        tick(); tick();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
